// File: rtl/ifu_pkg.sv
// Instruction-fetch front-end shared types and constants.
//   XLEN        : PC / target width
//   ADDR_SIZE   : predictor lookup tag width
//   INSTR_BYTES : bytes per fetched instruction word
//   fq_entry_t  : one fetch-queue slot (request metadata + returned instruction)
//   sat_inc     : saturating 32-bit increment for the optional perf counters
package ifu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned ADDR_SIZE   = 8;
  localparam int unsigned ILEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [ADDR_SIZE-1:0] tag;
    logic                 pred_dir;
    logic [XLEN-1:0]      pred_target;
    logic [ILEN-1:0]      instr;
    logic                 filled;
  } fq_entry_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'(1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch queue with three pointers:
//   alloc_ptr : next free slot, written when a request is accepted
//   fill_ptr  : oldest allocated slot still waiting for its response
//   pop_ptr   : head slot presented to decode
// Pointers carry one extra wrap bit so full/empty and the outstanding count
// fall out of plain subtraction.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   flush            : drop every entry (has priority over alloc/fill/pop)
//   alloc, alloc_entry : allocate tail slot with request metadata
//   fill, fill_instr : write instruction into the oldest unfilled slot
//   pop              : retire the head slot
//   head             : head slot contents
//   count            : slots allocated and not yet popped
//   pending          : slots allocated and not yet filled
module fetch_queue
  import ifu_pkg::*;
#(
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           alloc,
  input  fq_entry_t                      alloc_entry,
  input  logic                           fill,
  input  logic [ILEN-1:0]                fill_instr,
  input  logic                           pop,
  output fq_entry_t                      head,
  output logic [$clog2(FQ_DEPTH):0]      count,
  output logic [$clog2(FQ_DEPTH):0]      pending
);

  localparam int unsigned PW = $clog2(FQ_DEPTH);
  localparam int unsigned CW = PW + 1;

  fq_entry_t       mem [FQ_DEPTH];
  logic [CW-1:0]   alloc_ptr;
  logic [CW-1:0]   fill_ptr;
  logic [CW-1:0]   pop_ptr;

  // Slot storage and pointers; alloc, fill and pop always touch distinct slots.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      pop_ptr   <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      pop_ptr   <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) mem[i].filled <= 1'b0;
    end else begin
      if (alloc) begin
        mem[alloc_ptr[PW-1:0]] <= alloc_entry;
        alloc_ptr              <= alloc_ptr + CW'(1);
      end
      if (fill) begin
        mem[fill_ptr[PW-1:0]].instr  <= fill_instr;
        mem[fill_ptr[PW-1:0]].filled <= 1'b1;
        fill_ptr                     <= fill_ptr + CW'(1);
      end
      if (pop) begin
        mem[pop_ptr[PW-1:0]].filled <= 1'b0;
        pop_ptr                     <= pop_ptr + CW'(1);
      end
    end
  end

  assign head    = mem[pop_ptr[PW-1:0]];
  assign count   = alloc_ptr - pop_ptr;
  assign pending = alloc_ptr - fill_ptr;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, looks up the branch
// predictor, issues in-order imem requests, buffers responses with their
// prediction metadata for decode, and drains in-flight fetches on redirect.
// Optional build macro FETCH_PERF_EN adds saturating perf counters.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   bp_tag_o            : predictor lookup tag, pc[ADDR_SIZE+1:2]
//   bp_dir_i/target_i   : prediction for the current pc
//   imem_req_*          : request valid/ready and word-aligned address
//   imem_rsp_*          : in-order response valid and instruction word
//   dec_*               : head-of-queue instruction with pc/tag/prediction
//   exu_redirect_*      : redirect strobe and target pc
//   perf_*_o            : (FETCH_PERF_EN) accepted requests, redirects,
//                         cycles in FETCH blocked by full queue or !ready
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int unsigned     FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [ADDR_SIZE-1:0] bp_tag_o,
  input  logic                 bp_dir_i,
  input  logic [XLEN-1:0]      bp_target_i,
  output logic                 imem_req_valid_o,
  input  logic                 imem_req_ready_i,
  output logic [XLEN-1:0]      imem_addr_o,
  input  logic                 imem_rsp_valid_i,
  input  logic [ILEN-1:0]      imem_rsp_data_i,
  output logic                 dec_valid_o,
  input  logic                 dec_ready_i,
  output logic [ILEN-1:0]      dec_instr_o,
  output logic [XLEN-1:0]      dec_pc_o,
  output logic [ADDR_SIZE-1:0] dec_tag_o,
  output logic                 dec_pred_dir_o,
  output logic [XLEN-1:0]      dec_pred_target_o,
  input  logic                 exu_redirect_i,
  input  logic [XLEN-1:0]      exu_redirect_pc_i
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetch_o,
  output logic [31:0]          perf_flush_o,
  output logic [31:0]          perf_stall_o
`endif
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   drop_next;
  logic [CW-1:0]   drop_sum;
  logic [CW-1:0]   fq_count;
  logic [CW-1:0]   fq_pending;
  logic            accept;
  logic            fill;
  logic            pop;
  fq_entry_t       alloc_entry;
  fq_entry_t       head;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  // PC and in-flight drop counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      pc       <= pc_next;
      drop_cnt <= drop_next;
    end
  end

  // Next state, drop count and next pc. A response arriving with the redirect
  // is already home, so it is not counted as one to drop.
  always_comb begin
    state_next = state;
    drop_next  = drop_cnt;
    pc_next    = pc;
    drop_sum   = drop_cnt + fq_pending;
    if (exu_redirect_i) begin
      pc_next    = {exu_redirect_pc_i[XLEN-1:2], 2'b00};
      drop_next  = (imem_rsp_valid_i && drop_sum != '0) ? drop_sum - CW'(1) : drop_sum;
      state_next = (drop_next != '0) ? FLUSH : FETCH;
    end else begin
      if (accept) begin
        pc_next = bp_dir_i ? {bp_target_i[XLEN-1:2], 2'b00} : pc + XLEN'(INSTR_BYTES);
      end
      if (state == FLUSH) begin
        if (imem_rsp_valid_i && drop_cnt != '0) drop_next = drop_cnt - CW'(1);
        state_next = (drop_next == '0) ? FETCH : FLUSH;
      end
    end
  end

  // Request and queue control decode.
  always_comb begin
    imem_req_valid_o = 1'b0;
    accept           = 1'b0;
    fill             = 1'b0;
    pop              = 1'b0;
    if (rst_n && state == FETCH && !exu_redirect_i && fq_count < CW'(FQ_DEPTH)) begin
      imem_req_valid_o = 1'b1;
    end
    accept = imem_req_valid_o && imem_req_ready_i;
    fill   = imem_rsp_valid_i && state == FETCH && !exu_redirect_i;
    pop    = head.filled && dec_ready_i && !exu_redirect_i;
  end

  assign bp_tag_o    = pc[ADDR_SIZE+1:2];
  assign imem_addr_o = pc;

  always_comb begin
    alloc_entry             = '0;
    alloc_entry.pc          = pc;
    alloc_entry.tag         = pc[ADDR_SIZE+1:2];
    alloc_entry.pred_dir    = bp_dir_i;
    alloc_entry.pred_target = bp_target_i;
  end

  fetch_queue #(
    .FQ_DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (exu_redirect_i),
    .alloc       (accept),
    .alloc_entry (alloc_entry),
    .fill        (fill),
    .fill_instr  (imem_rsp_data_i),
    .pop         (pop),
    .head        (head),
    .count       (fq_count),
    .pending     (fq_pending)
  );

  assign dec_valid_o       = head.filled;
  assign dec_instr_o       = head.instr;
  assign dec_pc_o          = head.pc;
  assign dec_tag_o         = head.tag;
  assign dec_pred_dir_o    = head.pred_dir;
  assign dec_pred_target_o = head.pred_target;

`ifdef FETCH_PERF_EN
  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_o <= '0;
      perf_flush_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (accept)         perf_fetch_o <= sat_inc(perf_fetch_o);
      if (exu_redirect_i) perf_flush_o <= sat_inc(perf_flush_o);
      if (state == FETCH && !exu_redirect_i &&
          (fq_count == CW'(FQ_DEPTH) || !imem_req_ready_i)) begin
        perf_stall_o <= sat_inc(perf_stall_o);
      end
    end
  end
`endif

  // A response must always belong to a live or a dropped request.
  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid_i |-> (fq_pending != '0 || drop_cnt != '0));

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl with a one-cycle in-order imem model.
module tb_ifu_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  bp_tag_o;
  logic        bp_dir_i;
  logic [31:0] bp_target_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_instr_o;
  logic [31:0] dec_pc_o;
  logic [7:0]  dec_tag_o;
  logic        dec_pred_dir_o;
  logic [31:0] dec_pred_target_o;
  logic        exu_redirect_i;
  logic [31:0] exu_redirect_pc_i;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_o;
  logic [31:0] perf_flush_o;
  logic [31:0] perf_stall_o;
`endif

  int          checks;
  int          errors;
  int          n_acc;
  bit          mem_auto;
  logic [31:0] mq[$];

  ifu_fetch_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bp_tag_o          (bp_tag_o),
    .bp_dir_i          (bp_dir_i),
    .bp_target_i       (bp_target_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_addr_o       (imem_addr_o),
    .imem_rsp_valid_i  (imem_rsp_valid_i),
    .imem_rsp_data_i   (imem_rsp_data_i),
    .dec_valid_o       (dec_valid_o),
    .dec_ready_i       (dec_ready_i),
    .dec_instr_o       (dec_instr_o),
    .dec_pc_o          (dec_pc_o),
    .dec_tag_o         (dec_tag_o),
    .dec_pred_dir_o    (dec_pred_dir_o),
    .dec_pred_target_o (dec_pred_target_o),
    .exu_redirect_i    (exu_redirect_i),
    .exu_redirect_pc_i (exu_redirect_pc_i)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_o      (perf_fetch_o),
    .perf_flush_o      (perf_flush_o),
    .perf_stall_o      (perf_stall_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive the next queued response (instruction word = ~address).
  task automatic rsp_next();
    if (mq.size() > 0) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = ~mq.pop_front();
    end
  endtask

  // One clock: record an accept at the edge, then model the memory.
  task automatic cyc();
    logic        acc;
    logic [31:0] a;
    #1;
    acc = imem_req_valid_o & imem_req_ready_i;
    a   = imem_addr_o;
    @(posedge clk);
    #1;
    if (acc) begin
      mq.push_back(a);
      n_acc++;
    end
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    if (mem_auto) rsp_next();
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    bp_dir_i          = 1'b0;
    bp_target_i       = '0;
    imem_req_ready_i  = 1'b0;
    imem_rsp_valid_i  = 1'b0;
    imem_rsp_data_i   = '0;
    dec_ready_i       = 1'b0;
    exu_redirect_i    = 1'b0;
    exu_redirect_pc_i = '0;
    mem_auto          = 1'b0;
    mq.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid_o), 32'h0);
    chk("rst_dec_valid", 32'(dec_valid_o), 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_dec_pc", dec_pc_o, 32'h0);
    chk("rst_dec_instr", dec_instr_o, 32'h0);
    rst_n = 1'b1;
    n_acc = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_acc  = 0;

    // Sequential fetch, then a taken prediction at 0x8.
    do_reset();
    imem_req_ready_i = 1'b1;
    dec_ready_i      = 1'b1;
    mem_auto         = 1'b1;
    #1;
    chk("seq_first_valid", 32'(imem_req_valid_o), 32'h1);
    chk("seq_first_addr", imem_addr_o, 32'h0);
    cyc();
    chk("seq_addr_4", imem_addr_o, 32'h4);
    chk("seq_no_bypass", 32'(dec_valid_o), 32'h0);
    cyc();
    chk("seq_addr_8", imem_addr_o, 32'h8);
    chk("dec0_valid", 32'(dec_valid_o), 32'h1);
    chk("dec0_pc", dec_pc_o, 32'h0);
    chk("dec0_instr", dec_instr_o, 32'hFFFF_FFFF);
    chk("dec0_dir", 32'(dec_pred_dir_o), 32'h0);
    bp_dir_i    = 1'b1;
    bp_target_i = 32'h103;
    cyc();
    bp_dir_i = 1'b0;
    chk("taken_addr", imem_addr_o, 32'h100);
    chk("dec1_pc", dec_pc_o, 32'h4);
    chk("dec1_instr", dec_instr_o, 32'hFFFF_FFFB);
    cyc();
    chk("dec2_pc", dec_pc_o, 32'h8);
    chk("dec2_dir", 32'(dec_pred_dir_o), 32'h1);
    chk("dec2_target", dec_pred_target_o, 32'h103);
    chk("dec2_tag", 32'(dec_tag_o), 32'h2);
    chk("after_taken_addr", imem_addr_o, 32'h104);
    cyc();
    chk("dec3_pc", dec_pc_o, 32'h100);
    chk("dec3_tag", 32'(dec_tag_o), 32'h40);
    chk("dec3_dir", 32'(dec_pred_dir_o), 32'h0);

    // Full queue with decode stalled.
    do_reset();
    imem_req_ready_i = 1'b1;
    mem_auto         = 1'b1;
    repeat (4) cyc();
    chk("full_req_blocked", 32'(imem_req_valid_o), 32'h0);
    chk("full_acc4", 32'(n_acc), 32'd4);
    cyc();
    cyc();
    chk("full_still_blocked", 32'(imem_req_valid_o), 32'h0);
    chk("full_acc_still4", 32'(n_acc), 32'd4);
    chk("full_head_valid", 32'(dec_valid_o), 32'h1);
    chk("full_head_pc", dec_pc_o, 32'h0);
    dec_ready_i = 1'b1;
    cyc();
    dec_ready_i = 1'b0;
    chk("full_pop_reopens", 32'(imem_req_valid_o), 32'h1);
    chk("full_next_addr", imem_addr_o, 32'h10);
    chk("full_head_after_pop", dec_pc_o, 32'h4);
    cyc();
    chk("full_acc5", 32'(n_acc), 32'd5);
    chk("full_blocked_again", 32'(imem_req_valid_o), 32'h0);

    // Redirect with two requests in flight.
    do_reset();
    imem_req_ready_i = 1'b1;
    dec_ready_i      = 1'b1;
    cyc();
    cyc();
    chk("redir_pre_addr", imem_addr_o, 32'h8);
    exu_redirect_i    = 1'b1;
    exu_redirect_pc_i = 32'h201;
    mem_auto          = 1'b1;
    #1;
    chk("redir_blocks_req", 32'(imem_req_valid_o), 32'h0);
    cyc();
    exu_redirect_i = 1'b0;
    chk("flush_no_req0", 32'(imem_req_valid_o), 32'h0);
    chk("flush_pc", imem_addr_o, 32'h200);
    chk("flush_no_dec0", 32'(dec_valid_o), 32'h0);
    cyc();
    chk("flush_no_req1", 32'(imem_req_valid_o), 32'h0);
    chk("flush_no_dec1", 32'(dec_valid_o), 32'h0);
    cyc();
    chk("flush_done_req", 32'(imem_req_valid_o), 32'h1);
    chk("flush_done_addr", imem_addr_o, 32'h200);
    chk("flush_no_dec2", 32'(dec_valid_o), 32'h0);
    cyc();
    chk("flush_no_dec3", 32'(dec_valid_o), 32'h0);
    cyc();
    chk("redir_dec_valid", 32'(dec_valid_o), 32'h1);
    chk("redir_dec_pc", dec_pc_o, 32'h200);
    chk("redir_dec_instr", dec_instr_o, 32'hFFFF_FDFF);

    // Redirect together with a response and a pop.
    do_reset();
    imem_req_ready_i = 1'b1;
    repeat (3) cyc();
    imem_req_ready_i = 1'b0;
    rsp_next();
    cyc();
    chk("coin_head_valid", 32'(dec_valid_o), 32'h1);
    chk("coin_head_pc", dec_pc_o, 32'h0);
    rsp_next();
    dec_ready_i       = 1'b1;
    exu_redirect_i    = 1'b1;
    exu_redirect_pc_i = 32'h300;
    cyc();
    exu_redirect_i = 1'b0;
    dec_ready_i    = 1'b0;
    chk("coin_queue_empty", 32'(dec_valid_o), 32'h0);
    chk("coin_flush_noreq", 32'(imem_req_valid_o), 32'h0);
    rsp_next();
    imem_req_ready_i = 1'b1;
    cyc();
    chk("coin_one_drop_req", 32'(imem_req_valid_o), 32'h1);
    chk("coin_addr", imem_addr_o, 32'h300);
    chk("coin_no_dec", 32'(dec_valid_o), 32'h0);

    // PC wrap at the top of the address space.
    do_reset();
    exu_redirect_i    = 1'b1;
    exu_redirect_pc_i = 32'hFFFF_FFFF;
    cyc();
    exu_redirect_i   = 1'b0;
    imem_req_ready_i = 1'b1;
    dec_ready_i      = 1'b1;
    mem_auto         = 1'b1;
    #1;
    chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    chk("wrap_tag", 32'(bp_tag_o), 32'hFF);
    chk("wrap_valid", 32'(imem_req_valid_o), 32'h1);
    cyc();
    chk("wrap_next_addr", imem_addr_o, 32'h0);
    chk("wrap_next_tag", 32'(bp_tag_o), 32'h0);
`ifdef FETCH_PERF_EN
    chk("perf_fetch_1", perf_fetch_o, 32'd1);
    chk("perf_flush_1", perf_flush_o, 32'd1);
    chk("perf_stall_0", perf_stall_o, 32'd0);
`endif
    cyc();
    chk("wrap_dec_pc", dec_pc_o, 32'hFFFF_FFFC);
    chk("wrap_dec_tag", 32'(dec_tag_o), 32'hFF);
    chk("wrap_addr_4", imem_addr_o, 32'h4);
`ifdef FETCH_PERF_EN
    chk("perf_fetch_2", perf_fetch_o, 32'd2);
    imem_req_ready_i = 1'b0;
    cyc();
    chk("perf_stall_1", perf_stall_o, 32'd1);
    chk("perf_fetch_hold", perf_fetch_o, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
